// File: rtl/mux_rr_scheduler.sv
// Round-robin sequencer for a shared 8:1 data mux: grants one requester per burst and forwards its beats.
// Define MUX_SCHED_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module mux_rr_scheduler #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req,
  input  logic [7:0]            last,
  input  logic [8*DATA_W-1:0]   data_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            sel,
  output logic [7:0]            gnt,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state_reg;
  logic [2:0]       sel_reg;
  logic [7:0]       gnt_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
`ifndef MUX_SCHED_FIXED_PRIO_EN
  logic [2:0]       ptr_reg;
`endif

  logic [2:0]        cand_idx [8];
  logic [7:0]        cand_hit;
  logic [DATA_W-1:0] lane [8];
  logic [2:0]        pick;
  logic              found;
  logic              xfer;
  logic              burst_end;

  // Candidate k is the k-th index visited by the search; lowest k with a request wins.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cand
`ifdef MUX_SCHED_FIXED_PRIO_EN
    assign cand_idx[gi] = 3'(gi);
`else
    assign cand_idx[gi] = ptr_reg + 3'(gi + 1);
`endif
    assign cand_hit[gi] = req[cand_idx[gi]];
    assign lane[gi]     = data_in[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick  = cand_idx[k];
        found = 1'b1;
      end
    end
  end

  assign busy      = (state_reg == BURST);
  assign out_valid = busy & req[sel_reg];
  assign out_data  = lane[sel_reg];
  assign sel       = sel_reg;
  assign gnt       = gnt_reg;
  assign xfer      = out_valid & out_ready;
  assign burst_end = xfer & (last[sel_reg] | (beat_cnt_reg == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= 3'd0;
      gnt_reg      <= 8'd0;
      beat_cnt_reg <= '0;
`ifndef MUX_SCHED_FIXED_PRIO_EN
      ptr_reg      <= 3'd7;
`endif
    end else if (state_reg == IDLE) begin
      if (found) begin
        sel_reg      <= pick;
        gnt_reg      <= 8'd1 << pick;
        beat_cnt_reg <= '0;
        state_reg    <= BURST;
      end
    end else begin
      // A dropped request or the final beat both hand the channel back via IDLE.
      if (!req[sel_reg] || burst_end) begin
        gnt_reg   <= 8'd0;
        state_reg <= IDLE;
`ifndef MUX_SCHED_FIXED_PRIO_EN
        ptr_reg   <= sel_reg;
`endif
      end
      if (xfer) begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule
